// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Parametrised single-clock FIFO with occupancy count, threshold
//            flags, sticky error flags and optional first-word-fall-through.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [DATA_WIDTH-1:0]     data_write,
  input  logic                      write_enable,
  input  logic                      read_enable,
  input  logic                      clr_err,
  output logic [DATA_WIDTH-1:0]     data_read,
  output logic                      wfull,
  output logic                      rempty,
  output logic                      half_full,
  output logic                      half_rempty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;

  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(DEPTH / 2);
  localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESH);
  localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_THRESH);

  // Reject illegal configurations while elaborating rather than in silicon.
  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH - 1) begin : g_bad_thresh
      $error("sync_fifo_param: need 1 <= AE_THRESH < AF_THRESH <= DEPTH-1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_param: DATA_WIDTH must be >= 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0]   r_wptr;
  logic [c_addr_w-1:0]   r_rptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wa;
  logic w_ra;

  // Acceptance uses the flags as they stand before the edge.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_wa    = write_enable && !w_full;
  assign w_ra    = read_enable  && !w_empty;

  always_ff @(posedge wclk) begin
    if (w_wa) begin
      r_mem[r_wptr] <= data_write;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wa) begin
        r_wptr <= r_wptr + c_addr_w'(1);
      end
      if (w_ra) begin
        r_rptr <= r_rptr + c_addr_w'(1);
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A set condition wins over a clear on the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (read_enable && w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_read = w_empty ? '0 : r_mem[r_rptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_data_read;
      always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
          r_data_read <= '0;
        end else if (w_ra) begin
          r_data_read <= r_mem[r_rptr];
        end
      end
      assign data_read = r_data_read;
    end
  endgenerate

  assign count        = r_count;
  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign half_full    = (r_count >= c_half);
  assign half_rempty  = (r_count <= c_half);
  assign almost_full  = (r_count >= c_af);
  assign almost_empty = (r_count <= c_ae);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Directed bench for sync_fifo_param, standard and FWFT instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  logic       wclk;
  logic       s_rst_n, s_we, s_re, s_clr;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_hf, s_he, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_cnt;

  logic       f_rst_n, f_we, f_re, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_hf, f_he, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_cnt;

  int n_vec;
  int n_miss;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .wclk(wclk), .wrst_n(s_rst_n), .data_write(s_din), .write_enable(s_we),
    .read_enable(s_re), .clr_err(s_clr), .data_read(s_dout), .wfull(s_full),
    .rempty(s_empty), .half_full(s_hf), .half_rempty(s_he), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .wclk(wclk), .wrst_n(f_rst_n), .data_write(f_din), .write_enable(f_we),
    .read_enable(f_re), .clr_err(f_clr), .data_read(f_dout), .wfull(f_full),
    .rempty(f_empty), .half_full(f_hf), .half_rempty(f_he), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic check_std_reset(input string tag);
    check({tag, " count"}, 32'(s_cnt), 32'd0);
    check({tag, " rempty"}, 32'(s_empty), 32'd1);
    check({tag, " half_rempty"}, 32'(s_he), 32'd1);
    check({tag, " almost_empty"}, 32'(s_ae), 32'd1);
    check({tag, " wfull"}, 32'(s_full), 32'd0);
    check({tag, " half_full"}, 32'(s_hf), 32'd0);
    check({tag, " almost_full"}, 32'(s_af), 32'd0);
    check({tag, " overflow"}, 32'(s_ovf), 32'd0);
    check({tag, " underflow"}, 32'(s_unf), 32'd0);
    check({tag, " data_read"}, 32'(s_dout), 32'd0);
  endtask

  logic [7:0] exp_q [$];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    s_rst_n = 1'b0; s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0; s_din = 8'h00;
    f_rst_n = 1'b0; f_we = 1'b0; f_re = 1'b0; f_clr = 1'b0; f_din = 8'h00;
    tick; tick;
    check_std_reset("reset");
    check("fwft reset data_read", 32'(f_dout), 32'd0);
    check("fwft reset rempty", 32'(f_empty), 32'd1);
    s_rst_n = 1'b1;
    f_rst_n = 1'b1;

    // Fill with 0x00..0x0F, checking every flag at every occupancy.
    for (int i = 0; i < 16; i++) begin
      s_din = 8'(i); s_we = 1'b1;
      tick;
      check("fill count", 32'(s_cnt), 32'(i + 1));
      check("fill half_full", 32'(s_hf), 32'((i + 1) >= 8));
      check("fill half_rempty", 32'(s_he), 32'((i + 1) <= 8));
      check("fill almost_full", 32'(s_af), 32'((i + 1) >= 14));
      check("fill wfull", 32'(s_full), 32'((i + 1) == 16));
      check("fill rempty", 32'(s_empty), 32'd0);
      check("fill almost_empty", 32'(s_ae), 32'((i + 1) <= 2));
    end

    s_din = 8'hAA;
    tick;
    check("ovf count", 32'(s_cnt), 32'd16);
    check("ovf flag", 32'(s_ovf), 32'd1);
    s_we = 1'b0; s_clr = 1'b1;
    tick;
    check("ovf cleared", 32'(s_ovf), 32'd0);
    s_clr = 1'b0;

    for (int i = 0; i < 16; i++) begin
      s_re = 1'b1;
      tick;
      check("drain data", 32'(s_dout), 32'(i));
      check("drain count", 32'(s_cnt), 32'(15 - i));
    end
    check("drain rempty", 32'(s_empty), 32'd1);

    // Read on empty: rejected, sticky underflow, data held.
    tick;
    check("unf flag", 32'(s_unf), 32'd1);
    check("unf count", 32'(s_cnt), 32'd0);
    check("unf data held", 32'(s_dout), 32'h0F);
    s_re = 1'b0; s_clr = 1'b1;
    tick;
    check("unf cleared", 32'(s_unf), 32'd0);
    s_re = 1'b1;
    tick;
    check("unf set wins clr", 32'(s_unf), 32'd1);
    s_re = 1'b0;
    tick;
    check("unf clr after", 32'(s_unf), 32'd0);
    s_clr = 1'b0;

    // Occupancy 5 then 20 cycles of simultaneous traffic across the wrap.
    for (int i = 0; i < 5; i++) begin
      s_din = 8'h10 + 8'(i); s_we = 1'b1;
      tick;
    end
    check("pre-stream count", 32'(s_cnt), 32'd5);
    s_re = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_din = 8'h15 + 8'(i);
      tick;
      check("stream data", 32'(s_dout), 32'h10 + 32'(i));
      check("stream count", 32'(s_cnt), 32'd5);
    end
    check("stream overflow", 32'(s_ovf), 32'd0);
    check("stream underflow", 32'(s_unf), 32'd0);

    // Remaining contents 0x24..0x28; top up with 0x30..0x3A to full.
    s_re = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h24 + 8'(i));
    for (int i = 0; i < 11; i++) begin
      s_din = 8'h30 + 8'(i);
      exp_q.push_back(s_din);
      tick;
    end
    check("refill full", 32'(s_full), 32'd1);
    s_din = 8'h55; s_re = 1'b1;
    tick;
    check("full rw data", 32'(s_dout), 32'(exp_q.pop_front()));
    check("full rw count", 32'(s_cnt), 32'd15);
    check("full rw overflow", 32'(s_ovf), 32'd1);
    s_we = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      check("full rw drain", 32'(s_dout), 32'(exp_q.pop_front()));
    end
    check("drained empty", 32'(s_empty), 32'd1);
    s_din = 8'h33; s_we = 1'b1;
    tick;
    check("empty rw count", 32'(s_cnt), 32'd1);
    check("empty rw underflow", 32'(s_unf), 32'd1);
    check("empty rw data held", 32'(s_dout), 32'h3A);
    s_we = 1'b0;
    tick;
    check("empty rw stored", 32'(s_dout), 32'h33);
    s_re = 1'b0;

    // Asynchronous reset mid-burst, away from any clock edge.
    for (int i = 0; i < 9; i++) begin
      s_din = 8'h60 + 8'(i); s_we = 1'b1;
      tick;
    end
    check("burst half_full", 32'(s_hf), 32'd1);
    #2 s_rst_n = 1'b0;
    #1 check_std_reset("async reset");
    s_we = 1'b0;
    tick;
    s_rst_n = 1'b1;
    s_din = 8'h77; s_we = 1'b1;
    tick;
    check("post-reset first write", 32'(s_cnt), 32'd1);
    s_we = 1'b0;

    // FWFT: head word visible without a read.
    f_din = 8'h3C; f_we = 1'b1;
    tick;
    f_we = 1'b0;
    check("fwft head", 32'(f_dout), 32'h3C);
    check("fwft rempty", 32'(f_empty), 32'd0);
    tick;
    check("fwft head held", 32'(f_dout), 32'h3C);
    f_re = 1'b1;
    tick;
    f_re = 1'b0;
    check("fwft empty data", 32'(f_dout), 32'd0);
    check("fwft empty flag", 32'(f_empty), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      f_din = 8'(i); f_we = 1'b1;
      tick;
      check("fwft burst head", 32'(f_dout), 32'h01);
    end
    f_re = 1'b1;
    tick;
    check("fwft advance", 32'(f_dout), 32'h02);
    check("fwft rw count", 32'(f_cnt), 32'd3);
    #2 f_rst_n = 1'b0;
    #1;
    check("fwft rst data", 32'(f_dout), 32'd0);
    check("fwft rst count", 32'(f_cnt), 32'd0);
    check("fwft rst rempty", 32'(f_empty), 32'd1);
    check("fwft rst almost_empty", 32'(f_ae), 32'd1);
    f_we = 1'b0; f_re = 1'b0;
    tick;
    f_rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8-bit FIFO interface, generalised in data width, depth and read mode.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags with a clear input.
- Sits between a producer and a consumer sharing one clock; keeps the existing signal names (data_write, write_enable, read_enable, data_read, wfull, rempty, half_full, half_rempty) so current benches carry over.

Parameters:
- DATA_WIDTH, 8, width of data_write/data_read.
- DEPTH, 16, number of entries; must be a power of 2 and >= 4.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- Legality: 1 <= AE_THRESH < AF_THRESH <= DEPTH-1. Any violation is an elaboration-time error.

Ports:
- wclk  input  1  the single clock; all state updates on its rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- data_write  input  DATA_WIDTH  write data.
- write_enable  input  1  write request.
- read_enable  input  1  read request.
- clr_err  input  1  clears the sticky overflow/underflow flags.
- data_read  output  DATA_WIDTH  read data.
- wfull  output  1  count == DEPTH.
- rempty  output  1  count == 0.
- half_full  output  1  count >= DEPTH/2.
- half_rempty  output  1  count <= DEPTH/2.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, not reset.
- Pointers: wptr and rptr, each $clog2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
- Write accepted (wa) = write_enable && !wfull. On wa, mem[wptr] <= data_write and wptr increments.
- Read accepted (ra) = read_enable && !rempty. On ra, rptr increments.
- Acceptance is judged on pre-edge flags.
  - When full, a simultaneous write is rejected while the read proceeds.
  - When empty, a simultaneous read is rejected while the write proceeds.
- Count update per edge: wa only, +1; ra only, -1; both or neither, unchanged.
- All flags are decoded from the registered count and change on the same edge as count.
- half_full and half_rempty are both 1 when count == DEPTH/2.
- Standard mode (FWFT=0):
  - On ra, data_read <= mem[rptr]; the value is visible the cycle after the read is accepted.
  - data_read holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_read = mem[rptr] whenever !rempty; the head word is visible with zero read latency.
  - data_read is forced to 0 while rempty.
  - ra advances to the next word, which is visible after the edge.
  - A word written into an empty FIFO is visible the cycle after its write edge.
- Error flags:
  - overflow sets on write_enable && wfull; underflow sets on read_enable && rempty.
  - Both stay set until an edge with clr_err = 1.
  - If a set condition and clr_err occur on the same edge, the flag ends set.
- Reset (wrst_n low, asynchronous, at any time including mid-transfer):
  - wptr = rptr = 0, count = 0, data_read = 0.
  - rempty = 1, half_rempty = 1, almost_empty = 1.
  - wfull = 0, half_full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Stored contents are discarded.
  - Reset release is synchronous to wclk; the first write is accepted on the first rising edge after deassertion.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (defaults) -> count steps 1..16; half_full at count 8; almost_full at 14; wfull at 16; rempty and almost_empty clear at count 1 and 3 respectively.
- Full FIFO, write 0xAA -> rejected; count stays 16; overflow = 1. Then clr_err -> overflow = 0. Drain 16 words with FWFT=0 -> data_read = 0x00..0x0F, each one cycle after its read; rempty at the end.
- Empty FIFO, read_enable for 1 cycle -> underflow = 1; count stays 0; data_read unchanged. The same edge also carrying clr_err -> underflow still ends 1.
- count = 5, simultaneous write and read for 20 cycles across pointer wrap -> count stays 5; data order preserved; no error flags.
- Full FIFO, simultaneous write 0x55 and read -> read returns the oldest word; write rejected; count = 15; overflow = 1. Empty FIFO, simultaneous write 0x33 and read -> write stored; count = 1; underflow = 1.
- FWFT=1: write 0x3C into an empty FIFO -> data_read = 0x3C the next cycle with no read issued; read -> data_read = 0 and rempty = 1. Assert wrst_n low mid-burst -> all outputs return to reset values immediately.
